fetch_unit: RTL and testbench

- Stage1 (IF) of the ERV25 five-stage pipeline.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request channel with a response channel.
- Holds the fetched word until the F/D latch accepts it.
- Obeys enable_F_D/flush_F_D from pipeline control and redirects on a taken branch resolved in EX.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ERV25 pipeline stages.
package pipeline_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;  // addi x0, x0, 0

  // Fetch sequencer states. WAIT and DRAIN both have a request in flight.
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // True while a memory request has been accepted but not yet answered.
  function automatic logic fetch_outstanding(input fetch_state_t s);
    return (s == WAIT) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one instruction-memory request at a time,
// and holds the returned word for the F/D latch. A taken branch from EX
// redirects the PC in any state; a response belonging to a request that
// was superseded by a redirect is drained and dropped.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                 XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            enable_F_D,
  input  logic            flush_F_D,
  output logic [XLEN-1:0] instr_F,
  output logic [XLEN-1:0] pc_F,
  output logic            valid_F,
  output logic            busy
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] r_instr_f;
  logic [XLEN-1:0] w_instr_next;
  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] w_pc_f_next;
  logic            r_valid_f;
  logic            w_valid_next;
  logic            r_req_en;
  logic            r_busy;
  logic            w_req_fire;

  // r_req_en keeps the request line low while in reset and for the reset
  // cycle itself; it rises on the first clock edge after release.
  assign imem_req_valid = r_req_en && (r_state == REQ);
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_pc_inc       = r_pc + XLEN'(PC_STEP);  // wraps modulo 2^XLEN

  assign instr_F = r_instr_f;
  assign pc_F    = r_pc_f;
  assign valid_F = r_valid_f;
  assign busy    = r_busy;

  // Next-state, next-PC and F/D output decode; redirect overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr_f;
    w_pc_f_next  = r_pc_f;
    w_valid_next = r_valid_f;
    if (redirect_valid) begin
      w_pc_next    = redirect_pc;
      w_valid_next = 1'b0;
      case (r_state)
        REQ:     w_state_next = w_req_fire ? DRAIN : REQ;
        WAIT:    w_state_next = imem_rsp_valid ? REQ : DRAIN;
        HOLD:    w_state_next = REQ;
        // An answer arriving now retires the only outstanding request.
        DRAIN:   w_state_next = imem_rsp_valid ? REQ : DRAIN;
        default: w_state_next = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          // Responses seen here are stale (e.g. from before a reset).
          if (w_req_fire) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            w_instr_next = imem_rsp_data;
            w_pc_f_next  = r_pc;
            w_valid_next = 1'b1;
            w_state_next = HOLD;
          end
        end
        HOLD: begin
          // Accepted or flushed: either way the held word is done with.
          if (enable_F_D || flush_F_D) begin
            w_pc_next    = w_pc_inc;
            w_valid_next = 1'b0;
            w_state_next = REQ;
          end
        end
        DRAIN: begin
          w_valid_next = 1'b0;
          if (imem_rsp_valid) begin
            w_state_next = REQ;
          end
        end
        default: begin
          w_valid_next = 1'b0;
          w_state_next = REQ;
        end
      endcase
    end
  end

  // Sequencer state and program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Word, PC and valid offered to the F/D latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_f <= XLEN'(INSTR_NOP);
      r_pc_f    <= '0;
      r_valid_f <= 1'b0;
    end else begin
      r_instr_f <= w_instr_next;
      r_pc_f    <= w_pc_f_next;
      r_valid_f <= w_valid_next;
    end
  end

  // Request enable after reset release and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_req_en <= 1'b1;
      r_busy   <= fetch_outstanding(w_state_next);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked by a scoreboard that predicts the program-order fetch stream.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        enable_F_D;
  logic        flush_F_D;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic        valid_F;
  logic        busy;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .enable_F_D     (enable_F_D),
    .flush_F_D      (flush_F_D),
    .instr_F        (instr_F),
    .pc_F           (pc_F),
    .valid_F        (valid_F),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int deliveries = 0;

  // Memory-model controls and state.
  int          lat_cfg  = 1;   // 0 = random latency 1..3
  logic        stale    = 1'b0;
  logic        mem_pend = 1'b0;

  // Scoreboard: expected PC of the next instruction the stage will present.
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'hA;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      if (valid_F) return;
      step();
    end
    n_checks++;
    $display("FAIL wait_valid: valid_F never rose within 60 cycles");
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 60; i++) begin
      if (busy) return;
      step();
    end
    n_checks++;
    $display("FAIL wait_busy: busy never rose within 60 cycles");
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid_F", {31'd0, valid_F}, 32'd0);
    chk("rst_instr_F", instr_F, 32'h0000_0013);
    chk("rst_pc_F", pc_F, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  // Instruction memory: one outstanding request, response after lat cycles.
  initial begin
    logic        hs;
    logic        rsp_now;
    logic [31:0] a;
    logic [31:0] paddr;
    int          cnt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    paddr = '0;
    cnt   = 0;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready && !rst;
      rsp_now = imem_rsp_valid && !rst;
      a       = imem_addr;
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        mem_pend = 1'b0;
      end else begin
        if (rsp_now) mem_pend = 1'b0;
        if (hs) begin
          mem_pend = 1'b1;
          cnt   = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
          paddr = a;
        end
        if (mem_pend) begin
          if (cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
          end else begin
            cnt--;
          end
        end else if (stale) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  logic        prev_valid   = 1'b0;
  logic        prev_stall   = 1'b0;
  logic        prev_reqwait = 1'b0;
  logic [31:0] prev_pcf     = '0;
  logic [31:0] prev_instr   = '0;
  logic [31:0] prev_addr    = '0;
  logic [31:0] cur_pc       = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      prev_valid   = 1'b0;
      prev_stall   = 1'b0;
      prev_reqwait = 1'b0;
    end else begin
      if (valid_F && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_valid: pc_F %h presented with nothing expected", pc_F);
        end else begin
          cur_pc = exp_q.pop_front();
          deliveries++;
          $display("instr pc=%h data=%h", pc_F, instr_F);
          chk("sb_pc_F", pc_F, cur_pc);
          chk("sb_instr_F", instr_F, mem_word(cur_pc));
        end
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, valid_F}, 32'd1);
        chk("stall_pc_F", pc_F, prev_pcf);
        chk("stall_instr_F", instr_F, prev_instr);
      end
      if (valid_F) chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
      if (prev_reqwait) begin
        chk("req_held", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr_stable", imem_addr, prev_addr);
      end
      chk("busy", {31'd0, busy}, {31'd0, mem_pend});
      if (imem_req_valid && imem_req_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_addr: request %h issued with nothing expected", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_q[0]);
        end
      end
      // Effect of the coming clock edge on the expected fetch stream.
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end else if (valid_F && (enable_F_D || flush_F_D)) begin
        exp_q.push_back(cur_pc + 32'd4);
      end
      prev_valid   = valid_F;
      prev_stall   = valid_F && !enable_F_D && !flush_F_D && !redirect_valid;
      prev_pcf     = pc_F;
      prev_instr   = instr_F;
      prev_reqwait = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr    = imem_addr;
    end
  end

  // Stimulus.
  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    enable_F_D     = 1'b0;
    flush_F_D      = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    step();
    step();

    // Back-to-back fetch with a zero-wait memory: one word every 3 cycles.
    enable_F_D = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("valid_timing_c%0d", k), {31'd0, valid_F}, (k % 3 == 0) ? 32'd1 : 32'd0);
    end

    // Memory back-pressure: request must stay up with a stable address.
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'h0000_000C);
    end
    imem_req_ready = 1'b1;
    step();
    chk("bp_handshake_busy", {31'd0, busy}, 32'd1);

    // F/D stall: held word stays put, no new request.
    enable_F_D = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_pc", pc_F, 32'h0000_000C);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    enable_F_D = 1'b1;
    step();
    chk("after_stall_addr", imem_addr, 32'h0000_0010);

    // Redirect while waiting on a slow response.
    lat_cfg = 3;
    wait_busy();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_valid", {31'd0, valid_F}, 32'd0);
    wait_valid();
    chk("redir_pc_F", pc_F, 32'h0000_0100);

    // Redirect in the same cycle as the response.
    lat_cfg = 1;
    wait_busy();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("same_cyc_busy", {31'd0, busy}, 32'd0);
    chk("same_cyc_valid", {31'd0, valid_F}, 32'd0);
    chk("same_cyc_req", {31'd0, imem_req_valid}, 32'd1);
    chk("same_cyc_addr", imem_addr, 32'h0000_0200);

    // Flush of a held word at 0x20.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    enable_F_D     = 1'b0;
    step();
    redirect_valid = 1'b0;
    wait_valid();
    chk("flush_pc_F", pc_F, 32'h0000_0020);
    flush_F_D = 1'b1;
    step();
    flush_F_D = 1'b0;
    chk("flush_valid", {31'd0, valid_F}, 32'd0);
    chk("flush_req", {31'd0, imem_req_valid}, 32'd1);
    chk("flush_addr", imem_addr, 32'h0000_0024);

    // Reset mid-request, then a stale response right after release.
    enable_F_D = 1'b1;
    lat_cfg    = 3;
    wait_busy();
    rst = 1'b1;
    #1 chk_reset_vals();
    step();
    step();
    rst   = 1'b0;
    stale = 1'b1;
    step();
    stale = 1'b0;
    chk("stale_valid", {31'd0, valid_F}, 32'd0);
    chk("stale_req", {31'd0, imem_req_valid}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0000_0000);

    // PC wrap from the top of the address space.
    lat_cfg        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid();
    chk("wrap_pc_F", pc_F, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic.
    lat_cfg = 0;
    for (int k = 0; k < 3000; k++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      enable_F_D     = ($urandom_range(0, 9) < 7);
      flush_F_D      = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = 32'hFFFF_FFFC;
        1:       redirect_pc = $urandom;
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      step();
    end
    redirect_valid = 1'b0;
    flush_F_D      = 1'b0;
    repeat (5) step();
    chk("progress", {31'd0, (deliveries > 100)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
